// File: rtl/mfp_ahb_uart_tx.sv
// AHB-Lite slave UART transmitter: DATA/STATUS registers, transmit FIFO and an
// 8N1 serialiser with a registered, idle-high output line.
module mfp_ahb_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic        UART_TX
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic [BW-1:0]   baud, baud_next;
  logic [2:0]      bit_idx, bit_next;
  logic [7:0]      shreg;
  logic            tx_next;
  logic            pop;

  logic            dp_write;
  logic [1:0]      dp_addr;
  logic            addr_read;
  logic            push_req, push, stat_wr, ovf_set;
  logic            overflow;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            empty, full, busy;
  logic [31:0]     status_word;
  logic            unused_bits;

  assign HREADY = 1'b1;
  assign HRESP  = 1'b0;

  // HSIZE and the undecoded address/data bits are accepted but have no effect.
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HSIZE, HTRANS[0], HWDATA[31:8]};

  assign addr_read = HSEL & HTRANS[1] & ~HWRITE;

  // Address phase is latched here; writes are acted on one cycle later.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else begin
      dp_write <= HSEL & HTRANS[1] & HWRITE;
      dp_addr  <= HADDR[3:2];
    end
  end

  assign push_req = dp_write && (dp_addr == 2'd0);
  assign stat_wr  = dp_write && (dp_addr == 2'd1);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign busy  = (state != IDLE);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push    = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  assign status_word = {28'b0, overflow, full, empty, busy};

  // Read data is registered at the address-phase edge so it is valid throughout the data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HRDATA <= '0;
    end else if (addr_read && (HADDR[3:2] == 2'd1)) begin
      HRDATA <= status_word;
    end else begin
      HRDATA <= '0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= HWDATA[7:0];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (stat_wr && HWDATA[3]) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      UART_TX <= 1'b1;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_next;
      UART_TX <= tx_next;
      if (pop) begin
        shreg <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_idx;
    pop        = 1'b0;
    tx_next    = 1'b1;
    case (state)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud == BAUD_LAST) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud + BAUD_ONE;
        end
      end
      DATA: begin
        tx_next = shreg[bit_idx];
        if (baud == BAUD_LAST) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            bit_next   = '0;
            state_next = STOP;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end else begin
          baud_next = baud + BAUD_ONE;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (baud == BAUD_LAST) begin
          baud_next = '0;
          if (!empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud + BAUD_ONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// Scoreboard bench for mfp_ahb_uart_tx: bytes written to DATA are queued and
// matched against frames decoded from UART_TX.
module tb_mfp_ahb_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned FRAME = 10 * CPB;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        UART_TX;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0]  exp_q[$];
  bit          in_frame = 0;
  int unsigned mon_cnt = 0;
  int unsigned gap = 0;
  int unsigned last_gap = 0;
  int unsigned frames = 0;
  logic        samples[FRAME];

  mfp_ahb_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .UART_TX(UART_TX)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic finish_frame();
    logic       shape_ok;
    logic [7:0] rx;
    shape_ok = (samples[0] == 1'b0) && (samples[9*CPB] == 1'b1);
    for (int b = 0; b < 10; b++)
      for (int k = 1; k < CPB; k++)
        if (samples[b*CPB + k] !== samples[b*CPB]) shape_ok = 1'b0;
    for (int b = 0; b < 8; b++) rx[b] = samples[(b + 1) * CPB];
    frames++;
    check("frame_shape", {31'b0, shape_ok}, 32'd1);
    check("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) check("frame_byte", {24'b0, rx}, {24'b0, exp_q.pop_front()});
  endtask

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      in_frame = 0;
      mon_cnt  = 0;
      gap      = 0;
    end else if (!in_frame) begin
      if (UART_TX == 1'b0) begin
        in_frame   = 1;
        samples[0] = 1'b0;
        mon_cnt    = 1;
        last_gap   = gap;
        gap        = 0;
      end else begin
        gap++;
      end
    end else begin
      samples[mon_cnt] = UART_TX;
      mon_cnt++;
      if (mon_cnt == FRAME) begin
        in_frame = 0;
        finish_frame();
      end
    end
  end

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HADDR  = '0;
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    @(posedge HCLK); #1;
    bus_idle();
    data = HRDATA;
    @(posedge HCLK); #1;
  endtask

  // Pipelined DATA writes: each data phase overlaps the next address phase.
  task automatic data_burst(input logic [7:0] bytes[16], input int n);
    for (int i = 0; i < n; i++) begin
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
      if (i > 0) HWDATA = {24'b0, bytes[i-1]};
      @(posedge HCLK); #1;
    end
    bus_idle();
    HWDATA = {24'b0, bytes[n-1]};
    @(posedge HCLK); #1;
  endtask

  task automatic drain(input string tag);
    int unsigned i;
    i = 0;
    while ((exp_q.size() != 0 || in_frame) && i < 1000) begin
      @(negedge HCLK);
      i++;
    end
    check(tag, {31'b0, exp_q.size() == 0 && !in_frame}, 32'd1);
    @(posedge HCLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  bb[16];
    int unsigned f0, lows;

    bus_idle();
    HSIZE   = 3'b010;
    HWDATA  = '0;
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_tx", {31'b0, UART_TX}, 32'd1);
    check("rst_hrdata", HRDATA, 32'd0);
    check("hready", {31'b0, HREADY}, 32'd1);
    check("hresp", {31'b0, HRESP}, 32'd0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    ahb_read(32'h4, rd);
    check("status_reset", rd, 32'h2);
    check("tx_idle", {31'b0, UART_TX}, 32'd1);

    // Single byte with exact start-bit latency.
    exp_q.push_back(8'h55);
    ahb_write(32'h0, 32'h55);
    check("tx_e0", {31'b0, UART_TX}, 32'd1);
    @(posedge HCLK); #1;
    check("tx_e1", {31'b0, UART_TX}, 32'd1);
    @(posedge HCLK); #1;
    check("tx_fall_e2", {31'b0, UART_TX}, 32'd0);
    ahb_read(32'h4, rd);
    check("status_busy", rd, 32'h3);
    drain("drain_55");
    ahb_read(32'h4, rd);
    check("status_after_55", rd, 32'h2);

    // Back-to-back frames must not have an idle gap.
    bb[0] = 8'hA1; bb[1] = 8'h3C;
    exp_q.push_back(8'hA1); exp_q.push_back(8'h3C);
    data_burst(bb, 2);
    drain("drain_b2b");
    check("b2b_gap", last_gap, 32'd0);

    // Overflow: shifter plus a full FIFO, then one dropped byte.
    f0 = frames;
    for (int i = 0; i < 10; i++) begin
      bb[i] = 8'(8'h10 + 8'(i * 7));
      if (i < 9) exp_q.push_back(bb[i]);
    end
    data_burst(bb, 10);
    ahb_read(32'h4, rd);
    check("status_ovf", rd, 32'hD);
    ahb_write(32'h4, 32'h8);
    ahb_read(32'h4, rd);
    check("status_ovf_clr", rd, 32'h5);
    drain("drain_burst");
    check("burst_frames", frames - f0, 32'd9);
    ahb_read(32'h4, rd);
    check("status_after_burst", rd, 32'h2);

    // Reset in the middle of a frame.
    exp_q.push_back(8'h00);
    ahb_write(32'h0, 32'h00);
    for (int i = 0; i < 200 && !(in_frame && mon_cnt >= 13); i++) @(negedge HCLK);
    check("reach_bit3", {31'b0, in_frame && mon_cnt >= 13}, 32'd1);
    #1;
    check("tx_bit3_low", {31'b0, UART_TX}, 32'd0);
    HRESETn = 1'b0;
    #1;
    check("tx_async_rst", {31'b0, UART_TX}, 32'd1);
    exp_q.delete();
    f0 = frames;
    repeat (2) @(posedge HCLK);
    #2;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    ahb_read(32'h4, rd);
    check("status_post_rst", rd, 32'h2);
    lows = 0;
    repeat (60) begin
      @(negedge HCLK);
      if (UART_TX !== 1'b1) lows++;
    end
    check("no_residual_low", lows, 32'd0);
    check("no_residual_frame", frames - f0, 32'd0);

    // Unmapped offset: reads zero, writes are ignored.
    ahb_read(32'h8, rd);
    check("unmapped_read", rd, 32'h0);
    ahb_write(32'h8, 32'hFF);
    repeat (3) @(posedge HCLK);
    #1;
    ahb_read(32'h4, rd);
    check("status_unmapped", rd, 32'h2);
    repeat (20) @(posedge HCLK);
    #1;
    check("unmapped_no_frame", frames - f0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mfp_ahb_uart_tx.md
MFP_AHB_UART_TX -- requirements
Module: mfp_ahb_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning HCLK cycles per serial bit (50 MHz / 115200).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning transmit FIFO entries; power of 2, at least 2.
REQ-003 SHALL have port HCLK, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port HRESETn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port HSEL, input, 1 bit: slave select from the AHB-Lite decoder.
REQ-006 SHALL have port HADDR, input, 32 bits: address; only bits [3:2] are decoded.
REQ-007 SHALL have port HTRANS, input, 2 bits: transfer type; a transfer is active when HTRANS[1]=1.
REQ-008 SHALL have port HWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port HSIZE, input, 3 bits: transfer size; accepted and ignored, all accesses are treated as word.
REQ-010 SHALL have port HWDATA, input, 32 bits: write data, valid in the data phase.
REQ-011 SHALL have port HRDATA, output, 32 bits: read data, registered.
REQ-012 SHALL have port HREADY, output, 1 bit: tied to 1, no wait states.
REQ-013 SHALL have port HRESP, output, 1 bit: tied to 0, always OKAY.
REQ-014 SHALL have port UART_TX, output, 1 bit: serial line, 8N1, idle high.

Function
REQ-015 SHALL capture the address phase (HSEL & HTRANS[1]) as registered HADDR[3:2] and HWRITE, and act on it in the following data phase.
REQ-016 SHALL implement the register map: offset 0x0 DATA, offset 0x4 STATUS; every other offset reads 0 and ignores writes.
REQ-017 SHALL, on a DATA write, push HWDATA[7:0] into the FIFO at the end of the data-phase cycle; DATA reads return 0.
REQ-018 SHALL return on a STATUS read {28'b0, overflow, full, empty, busy}, where busy=1 whenever the FSM is not IDLE.
REQ-019 SHALL, on a STATUS write with HWDATA[3]=1, clear overflow; all other STATUS write bits are ignored.
REQ-020 SHALL, on a DATA write while full and no pop in the same cycle, drop the byte and set the sticky overflow bit; FIFO contents are unchanged.
REQ-021 SHALL, on a push and a pop in the same cycle while full, perform both; the occupancy count is unchanged and overflow is not set.
REQ-022 SHALL keep FIFO read/write pointers of log2(FIFO_DEPTH)+1 bits, wrapping modulo 2*FIFO_DEPTH; full and empty are derived from the pointers.
REQ-023 SHALL run the transmit FSM through IDLE -> START -> DATA -> STOP.
REQ-024 SHALL, in IDLE with the FIFO non-empty, pop the head into the shift register and enter START; UART_TX falls on the 2nd HCLK edge after the data-phase edge of the write.
REQ-025 SHALL drive each bit for exactly CLKS_PER_BIT cycles using a baud counter that reloads at every bit boundary.
REQ-026 SHALL drive START as 0, DATA as 8 bits LSB first under a 3-bit index, and STOP as 1; a frame is 10*CLKS_PER_BIT cycles.
REQ-027 SHALL, at the end of STOP with the FIFO non-empty, pop and enter START directly with no idle gap; otherwise it enters IDLE.
REQ-028 SHALL not alter the byte being shifted when the FIFO is written during a frame.
REQ-029 SHALL register UART_TX so that it is glitch-free.

Reset
REQ-030 SHALL, while HRESETn=0, immediately force UART_TX=1, HRDATA=0, FSM=IDLE, FIFO empty, overflow=0, and baud and bit counters to 0, including mid-frame.
REQ-031 SHALL resume operation on the first HCLK edge after HRESETn deasserts.

Verification
REQ-032 SHALL be covered by this scenario (CLKS_PER_BIT=4, FIFO_DEPTH=8): reset, then read STATUS -> 0x2; UART_TX=1 throughout.
REQ-033 SHALL be covered by this scenario: write 0x55 to DATA -> UART_TX reads 0,1,0,1,0,1,0,1,0,1, 4 cycles each, 40 cycles total; STATUS reads 0x2 afterwards.
REQ-034 SHALL be covered by this scenario: write 0xA1 then 0x3C back-to-back -> two frames with no idle cycle between stop bit and next start bit.
REQ-035 SHALL be covered by this scenario: write 10 bytes consecutively -> 9 frames sent (1 in the shifter plus 8 queued), 10th dropped, STATUS=0xD during the burst; then write 0x8 to STATUS -> overflow cleared.
REQ-036 SHALL be covered by this scenario: assert HRESETn=0 during bit 3 of a frame -> UART_TX=1 in the same cycle, and after release STATUS reads 0x2 with no residual frame.
REQ-037 SHALL be covered by this scenario: read offset 0x8, then write it with 0xFF -> HRDATA=0; no FIFO or flag change.
